multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle main controller for the RV32I subset core (lw, sw, R-type add/sub/xor, addi, bne). It replaces single-cycle opcode decode with a state machine that steps one instruction through fetch, decode, execute, memory and writeback over 3–5 cycles. It drives the shared-ALU/single-memory datapath and stalls on a ready handshake from the unified instruction/data memory. Unknown opcodes and memory timeouts halt the core in a trap state.

## Interface
- WAIT_LIMIT, 0: maximum stall cycles allowed per memory access; 0 disables the timeout; legal range 0–255.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous reset, active low.
- opcode  in  7  IR[6:0]; valid from DECODE onward.
- memReady  in  1  memory completes the current access in this cycle.
- MemRead  out  1  read request; held until memReady.
- MemWrite  out  1  write request; held until memReady.
- IorD  out  1  address mux select: 0 = PC, 1 = ALUOut.
- IRWrite  out  1  load IR and oldPC.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load when ALU Zero == 0 (bne).
- PCSource  out  1  PC input select: 0 = ALU result, 1 = ALUOut.
- ALUSrcA  out  2  00 = PC, 01 = oldPC, 10 = rs1.
- ALUSrcB  out  2  00 = rs2, 01 = constant 4, 10 = immediate.
- ALUOp  out  2  00 = add, 01 = subtract (compare), 10 = decode funct.
- RegWrite  out  1  register file write.
- MemToReg  out  1  writeback select: 0 = ALUOut, 1 = MDR.
- retire  out  1  one-cycle pulse in the final cycle of each instruction.
- trap  out  1  sticky halt indicator.
- state  out  4  current state encoding, for debug.

## Operation
- States and encodings: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMREAD=4, MEMWB=5, MEMWRITE=6, EXEC_R=7, EXEC_I=8, ALUWB=9, BRANCH=10, TRAP=11.
- Any output not listed for a state is 0.
- **IDLE:** all outputs 0. Next state is FETCH.
- **FETCH:** MemRead=1, IorD=0, ALUSrcA=00, ALUSrcB=01, ALUOp=00, PCSource=0.
  - IRWrite=1 and PCWrite=1 only in the cycle where memReady=1; the state then advances to DECODE.
  - Otherwise the state stays in FETCH.
- **DECODE:** ALUSrcA=01, ALUSrcB=10, ALUOp=00; this speculatively computes the branch target into ALUOut.
  - Next state by opcode: 0000011 or 0100011 → MEMADR; 0110011 → EXEC_R; 0010011 → EXEC_I; 1100011 → BRANCH.
  - Any other opcode → TRAP.
- **MEMADR:** ALUSrcA=10, ALUSrcB=10, ALUOp=00. Next state is MEMREAD for lw, MEMWRITE for sw.
- **MEMREAD:** MemRead=1, IorD=1. Advances to MEMWB on memReady.
- **MEMWB:** RegWrite=1, MemToReg=1, retire=1. Next state is FETCH.
- **MEMWRITE:** MemWrite=1, IorD=1. On memReady: retire=1 and next state is FETCH.
- **EXEC_R:** ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next state is ALUWB.
- **EXEC_I:** ALUSrcA=10, ALUSrcB=10, ALUOp=00. Next state is ALUWB.
- **ALUWB:** RegWrite=1, MemToReg=0, retire=1. Next state is FETCH.
- **BRANCH:** ALUSrcA=10, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=1, retire=1. Next state is FETCH.
- **TRAP:** trap=1; all other outputs 0. The state is absorbing until rst_n is asserted.
- **Wait counter:** 8 bits, cleared on every state change.
  - Increments each cycle spent in FETCH, MEMREAD or MEMWRITE with memReady=0.
  - If WAIT_LIMIT≠0 and the counter reaches WAIT_LIMIT while memReady=0, the next state is TRAP.
  - memReady=1 in the same cycle as the limit is reached takes priority: the access completes normally.
- memReady is ignored in all states other than FETCH, MEMREAD and MEMWRITE.

## Timing
- rst_n low forces state to IDLE, wait counter to 0 and all outputs to 0, immediately and independent of clk.
- Reset asserted mid-access drops MemRead/MemWrite asynchronously; the memory must tolerate request withdrawal.
- After rst_n rises, the first clk edge moves IDLE → FETCH.
- All outputs are combinational from the state register and memReady. The only memReady-qualified outputs are IRWrite and PCWrite in FETCH, and retire in MEMWRITE.
- Latency with zero wait states (FETCH through retire):
  - bne: 3 cycles.
  - R-type, addi, sw: 4 cycles.
  - lw: 5 cycles.
  - Each wait cycle adds 1.
- Each request is held stable from state entry until the memReady cycle inclusive; the next request begins the following cycle at the earliest.
- retire is exactly one cycle wide per instruction; no pulse is produced for a trapped instruction.

## Test plan
- Reset release, memReady tied to 1, IR = addi: state sequence 0,1,2,8,9,1; retire high only in the ALUWB cycle; all outputs 0 during reset.
- lw with memReady low for 2 cycles in FETCH and 1 cycle in MEMREAD: total 8 cycles; IRWrite and PCWrite pulse once, in FETCH cycle 3; MemToReg=1 and RegWrite=1 in MEMWB.
- bne: BRANCH cycle shows PCWriteCond=1, PCSource=1, ALUOp=01, ALUSrcA=10, ALUSrcB=00; next state is FETCH.
- Opcode 1111111 in DECODE: next state TRAP, trap=1, MemRead stays 0 for 20 cycles; rst_n pulse returns state to IDLE.
- WAIT_LIMIT=3, memReady held 0 in MEMWRITE: TRAP entered after 3 wait cycles. Repeat with memReady=1 in the limit cycle: retire=1 and next state is FETCH.
- rst_n dropped mid-MEMREAD: MemRead falls asynchronously and state reads 0 before the next clk edge.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle main controller for the RV32I subset core: steps each instruction
// through fetch/decode/execute/memory/writeback and halts in TRAP on faults.
module multicycle_control #(
    parameter int unsigned WAIT_LIMIT = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       memReady,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IorD,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       PCSource,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       RegWrite,
    output logic       MemToReg,
    output logic       retire,
    output logic       trap,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        MEMADR   = 4'd3,
        MEMREAD  = 4'd4,
        MEMWB    = 4'd5,
        MEMWRITE = 4'd6,
        EXEC_R   = 4'd7,
        EXEC_I   = 4'd8,
        ALUWB    = 4'd9,
        BRANCH   = 4'd10,
        TRAP     = 4'd11
    } stateT;

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic       TIMEOUT_EN = (WAIT_LIMIT != 0);
    localparam logic [8:0] LIMIT9     = 9'(WAIT_LIMIT);

    stateT      curState;
    stateT      nextState;
    logic [7:0] waitCount;
    logic       waiting;
    logic       timeoutHit;

    assign state = curState;

    // A stall cycle is one spent in a memory-request state without completion.
    assign waiting    = (curState == FETCH || curState == MEMREAD || curState == MEMWRITE)
                        && !memReady;
    assign timeoutHit = TIMEOUT_EN && waiting && (({1'b0, waitCount} + 9'd1) == LIMIT9);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            curState <= IDLE;
        end else begin
            curState <= nextState;
        end
    end

    // Counter restarts on every state change and saturates so it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waitCount <= 8'd0;
        end else if (nextState != curState) begin
            waitCount <= 8'd0;
        end else if (waiting && waitCount != 8'hFF) begin
            waitCount <= waitCount + 8'd1;
        end
    end

    always_comb begin
        nextState   = curState;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IorD        = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        PCSource    = 1'b0;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        RegWrite    = 1'b0;
        MemToReg    = 1'b0;
        retire      = 1'b0;
        trap        = 1'b0;

        case (curState)
            IDLE: begin
                nextState = FETCH;
            end
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                if (memReady) begin
                    IRWrite   = 1'b1;
                    PCWrite   = 1'b1;
                    nextState = DECODE;
                end else if (timeoutHit) begin
                    nextState = TRAP;
                end
            end
            DECODE: begin
                // Branch target is computed here speculatively into ALUOut.
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                case (opcode)
                    OP_LW, OP_SW: nextState = MEMADR;
                    OP_RTYPE:     nextState = EXEC_R;
                    OP_ITYPE:     nextState = EXEC_I;
                    OP_BRANCH:    nextState = BRANCH;
                    default:      nextState = TRAP;
                endcase
            end
            MEMADR: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b10;
                nextState = (opcode == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (memReady) begin
                    nextState = MEMWB;
                end else if (timeoutHit) begin
                    nextState = TRAP;
                end
            end
            MEMWB: begin
                RegWrite  = 1'b1;
                MemToReg  = 1'b1;
                retire    = 1'b1;
                nextState = FETCH;
            end
            MEMWRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (memReady) begin
                    retire    = 1'b1;
                    nextState = FETCH;
                end else if (timeoutHit) begin
                    nextState = TRAP;
                end
            end
            EXEC_R: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b00;
                ALUOp     = 2'b10;
                nextState = ALUWB;
            end
            EXEC_I: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b10;
                nextState = ALUWB;
            end
            ALUWB: begin
                RegWrite  = 1'b1;
                retire    = 1'b1;
                nextState = FETCH;
            end
            BRANCH: begin
                ALUSrcA     = 2'b10;
                ALUSrcB     = 2'b00;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 1'b1;
                retire      = 1'b1;
                nextState   = FETCH;
            end
            TRAP: begin
                trap      = 1'b1;
                nextState = TRAP;
            end
            default: begin
                nextState = TRAP;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: stimulus queues the expected state and
// control word per cycle, a negedge monitor pops and compares them.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = 7'b0;
    logic       memReady = 1'b0;
    logic       MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond, PCSource;
    logic [1:0] ALUSrcA, ALUSrcB, ALUOp;
    logic       RegWrite, MemToReg, retire, trap;
    logic [3:0] state;

    multicycle_control #(.WAIT_LIMIT(3)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .memReady(memReady),
        .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .RegWrite(RegWrite),
        .MemToReg(MemToReg), .retire(retire), .trap(trap), .state(state)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] AI = 7'b0010011, BN = 7'b1100011, BAD = 7'b1111111;

    // Fields: MR MW IorD IRW PCW PCWC PCS | ASA | ASB | OP | RW MTR RET TRAP
    localparam logic [16:0] C_IDLE   = 17'b0000000_00_00_00_0000;
    localparam logic [16:0] C_FWAIT  = 17'b1000000_00_01_00_0000;
    localparam logic [16:0] C_FRDY   = 17'b1001100_00_01_00_0000;
    localparam logic [16:0] C_DEC    = 17'b0000000_01_10_00_0000;
    localparam logic [16:0] C_MADR   = 17'b0000000_10_10_00_0000;
    localparam logic [16:0] C_MRD    = 17'b1010000_00_00_00_0000;
    localparam logic [16:0] C_MWB    = 17'b0000000_00_00_00_1110;
    localparam logic [16:0] C_MWWAIT = 17'b0110000_00_00_00_0000;
    localparam logic [16:0] C_MWRDY  = 17'b0110000_00_00_00_0010;
    localparam logic [16:0] C_EXR    = 17'b0000000_10_00_10_0000;
    localparam logic [16:0] C_EXI    = 17'b0000000_10_10_00_0000;
    localparam logic [16:0] C_AWB    = 17'b0000000_00_00_00_1010;
    localparam logic [16:0] C_BR     = 17'b0000011_10_00_01_0010;
    localparam logic [16:0] C_TRAP   = 17'b0000000_00_00_00_0001;

    typedef struct {
        string       tag;
        logic [3:0]  expState;
        logic [16:0] expCtrl;
    } expT;

    expT expQ[$];
    int  total = 0;
    int  bad = 0;

    wire [16:0] ctrlWord = {MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond,
                            PCSource, ALUSrcA, ALUSrcB, ALUOp, RegWrite, MemToReg,
                            retire, trap};

    task automatic checkOutput(input string tag, input logic [3:0] actState,
                               input logic [3:0] expState, input logic [16:0] actCtrl,
                               input logic [16:0] expCtrl);
        total++;
        if (actState !== expState || actCtrl !== expCtrl) begin
            bad++;
            $display("[TB] FAIL %s: state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                     tag, actState, actCtrl, expState, expCtrl);
        end
    endtask

    // Drive one cycle's inputs just after the edge and queue what that cycle must show.
    task automatic applyStimulus(input string tag, input logic [6:0] op, input logic rdy,
                                 input logic [3:0] expState, input logic [16:0] expCtrl);
        expT e;
        @(posedge clk);
        #1;
        opcode   = op;
        memReady = rdy;
        e.tag = tag;
        e.expState = expState;
        e.expCtrl = expCtrl;
        expQ.push_back(e);
    endtask

    task automatic releaseReset(input string tag);
        expT e;
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        memReady = 1'b1;
        e.tag = tag;
        e.expState = 4'd0;
        e.expCtrl = C_IDLE;
        expQ.push_back(e);
    endtask

    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            expT e;
            e = expQ.pop_front();
            checkOutput(e.tag, state, e.expState, ctrlWord, e.expCtrl);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // Outputs quiet while held in reset, then addi with memory always ready
        applyStimulus("rst0", AI, 1'b1, 4'd0, C_IDLE);
        applyStimulus("rst1", AI, 1'b1, 4'd0, C_IDLE);
        releaseReset("rstRelease");
        applyStimulus("addiFetch", AI, 1'b1, 4'd1, C_FRDY);
        applyStimulus("addiDecode", AI, 1'b1, 4'd2, C_DEC);
        applyStimulus("addiExec", AI, 1'b1, 4'd8, C_EXI);
        applyStimulus("addiWb", AI, 1'b1, 4'd9, C_AWB);

        // lw with two fetch stalls and one read stall: 8 cycles
        applyStimulus("lwFetchW1", LW, 1'b0, 4'd1, C_FWAIT);
        applyStimulus("lwFetchW2", LW, 1'b0, 4'd1, C_FWAIT);
        applyStimulus("lwFetchRdy", LW, 1'b1, 4'd1, C_FRDY);
        applyStimulus("lwDecode", LW, 1'b1, 4'd2, C_DEC);
        applyStimulus("lwMemAdr", LW, 1'b0, 4'd3, C_MADR);
        applyStimulus("lwReadW", LW, 1'b0, 4'd4, C_MRD);
        applyStimulus("lwReadRdy", LW, 1'b1, 4'd4, C_MRD);
        applyStimulus("lwWb", LW, 1'b0, 4'd5, C_MWB);

        // sw zero-wait, R-type, bne
        applyStimulus("swFetch", SW, 1'b1, 4'd1, C_FRDY);
        applyStimulus("swDecode", SW, 1'b1, 4'd2, C_DEC);
        applyStimulus("swMemAdr", SW, 1'b1, 4'd3, C_MADR);
        applyStimulus("swWriteRdy", SW, 1'b1, 4'd6, C_MWRDY);
        applyStimulus("rFetch", RT, 1'b1, 4'd1, C_FRDY);
        applyStimulus("rDecode", RT, 1'b1, 4'd2, C_DEC);
        applyStimulus("rExec", RT, 1'b1, 4'd7, C_EXR);
        applyStimulus("rWb", RT, 1'b1, 4'd9, C_AWB);
        applyStimulus("bneFetch", BN, 1'b1, 4'd1, C_FRDY);
        applyStimulus("bneDecode", BN, 1'b1, 4'd2, C_DEC);
        applyStimulus("bneBranch", BN, 1'b1, 4'd10, C_BR);

        // sw timing out after three stall cycles in MEMWRITE
        applyStimulus("toFetch", SW, 1'b1, 4'd1, C_FRDY);
        applyStimulus("toDecode", SW, 1'b1, 4'd2, C_DEC);
        applyStimulus("toMemAdr", SW, 1'b0, 4'd3, C_MADR);
        applyStimulus("toWait1", SW, 1'b0, 4'd6, C_MWWAIT);
        applyStimulus("toWait2", SW, 1'b0, 4'd6, C_MWWAIT);
        applyStimulus("toWait3", SW, 1'b0, 4'd6, C_MWWAIT);
        for (int i = 0; i < 4; i++) begin
            applyStimulus("toTrap", SW, i[0], 4'd11, C_TRAP);
        end

        // Asynchronous reset out of TRAP
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("trapAsyncRst", state, 4'd0, ctrlWord, C_IDLE);
        releaseReset("rstRelease2");

        // Ready arriving in the limit cycle wins over the timeout
        applyStimulus("limFetch", SW, 1'b1, 4'd1, C_FRDY);
        applyStimulus("limDecode", SW, 1'b1, 4'd2, C_DEC);
        applyStimulus("limMemAdr", SW, 1'b0, 4'd3, C_MADR);
        applyStimulus("limWait1", SW, 1'b0, 4'd6, C_MWWAIT);
        applyStimulus("limWait2", SW, 1'b0, 4'd6, C_MWWAIT);
        applyStimulus("limRdy", SW, 1'b1, 4'd6, C_MWRDY);

        // Unknown opcode traps and stays quiet for 20 cycles
        applyStimulus("badFetch", BAD, 1'b1, 4'd1, C_FRDY);
        applyStimulus("badDecode", BAD, 1'b1, 4'd2, C_DEC);
        for (int i = 0; i < 20; i++) begin
            applyStimulus("badTrap", BAD, 1'b1, 4'd11, C_TRAP);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("badAsyncRst", state, 4'd0, ctrlWord, C_IDLE);
        releaseReset("rstRelease3");

        // Reset dropped in the middle of a stalled MEMREAD
        applyStimulus("midFetch", LW, 1'b1, 4'd1, C_FRDY);
        applyStimulus("midDecode", LW, 1'b1, 4'd2, C_DEC);
        applyStimulus("midMemAdr", LW, 1'b0, 4'd3, C_MADR);
        applyStimulus("midRead", LW, 1'b0, 4'd4, C_MRD);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midReadAsyncRst", state, 4'd0, ctrlWord, C_IDLE);
        applyStimulus("midHeld", LW, 1'b1, 4'd0, C_IDLE);
        releaseReset("rstRelease4");
        applyStimulus("postFetch", AI, 1'b1, 4'd1, C_FRDY);

        @(negedge clk);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
